// File: rtl/lift_pkg.sv
// Shared definitions for the lift call scheduler: FSM encoding, default sizes
// and sweep-direction constants.
package lift_pkg;

    localparam int NUM_FLOORS_DEF = 8;
    localparam int FLOOR_W_DEF    = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SELECT = 2'd1;
    localparam state_t ST_ISSUE  = 2'd2;
    localparam state_t ST_WAIT   = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/lift_target_pick.sv
// SCAN target search: nearest pending floor ahead in the current direction,
// otherwise reverse and take the nearest pending floor behind.
module lift_target_pick
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur,
    input  logic                  dir_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    target,
    output logic                  new_dir
);

    logic               above_found;
    logic [FLOOR_W-1:0] above_floor;
    logic               below_found;
    logic [FLOOR_W-1:0] below_floor;

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        // Scan downward so the last hit is the lowest floor above cur.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && i > int'(cur)) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && i < int'(cur)) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        target  = '0;
        new_dir = dir_up;
        if (dir_up == DIR_UP) begin
            if (above_found) begin
                found  = 1'b1;
                target = above_floor;
            end else if (below_found) begin
                found   = 1'b1;
                target  = below_floor;
                new_dir = DIR_DOWN;
            end
        end else begin
            if (below_found) begin
                found  = 1'b1;
                target = below_floor;
            end else if (above_found) begin
                found   = 1'b1;
                target  = above_floor;
                new_dir = DIR_UP;
            end
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// Collects hall/cab calls into a pending bitmap and hands one SCAN-ordered
// target at a time to the Lift, retiring requests on arrival.
module lift_call_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
    parameter int FLOOR_W     = FLOOR_W_DEF,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hall_call_v,
    input  logic [FLOOR_W-1:0]    hall_call_floor,
    input  logic                  cab_call_v,
    input  logic [FLOOR_W-1:0]    cab_call_floor,
    input  logic [FLOOR_W-1:0]    elev_f_i,
    input  logic                  busy_i,
    output logic                  tgt_valid_o,
    output logic [FLOOR_W-1:0]    tgt_floor_o,
    output logic                  dir_up_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  served_o,
    output logic [FLOOR_W-1:0]    served_floor_o
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

    state_t                 state;
    logic [NUM_FLOORS-1:0]  pending;
    logic [NUM_FLOORS-1:0]  set_mask;
    logic [NUM_FLOORS-1:0]  clr_mask;
    logic                   dir_up;
    logic                   tgt_valid;
    logic [FLOOR_W-1:0]     tgt_floor;
    logic                   served;
    logic [FLOOR_W-1:0]     served_floor;
    logic [CNT_W-1:0]       cnt;
    logic                   cur_hit;
    logic                   retire_v;
    logic [FLOOR_W-1:0]     retire_floor;
    logic                   pick_found;
    logic [FLOOR_W-1:0]     pick_target;
    logic                   pick_dir;

    lift_target_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .pending (pending),
        .cur     (elev_f_i),
        .dir_up  (dir_up),
        .found   (pick_found),
        .target  (pick_target),
        .new_dir (pick_dir)
    );

    // Out-of-range floors never match a bit index, so they are dropped here.
    always_comb begin
        set_mask = '0;
        cur_hit  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (hall_call_v && int'(hall_call_floor) == i) set_mask[i] = 1'b1;
            if (cab_call_v && int'(cab_call_floor) == i)   set_mask[i] = 1'b1;
            if (pending[i] && int'(elev_f_i) == i)         cur_hit     = 1'b1;
        end
    end

    always_comb begin
        retire_v     = 1'b0;
        retire_floor = tgt_floor;
        if (state == ST_SELECT && cur_hit) begin
            retire_v     = 1'b1;
            retire_floor = elev_f_i;
        end else if (state == ST_WAIT && !busy_i && elev_f_i == tgt_floor) begin
            retire_v = 1'b1;
        end
        clr_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (retire_v && int'(retire_floor) == i) clr_mask[i] = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pending      <= '0;
            dir_up       <= DIR_UP;
            tgt_valid    <= 1'b0;
            tgt_floor    <= '0;
            served       <= 1'b0;
            served_floor <= '0;
            cnt          <= '0;
        end else begin
            // Clear beats a same-cycle set: the cabin is standing at that floor.
            pending <= (pending | set_mask) & ~clr_mask;
            served  <= retire_v;
            if (retire_v) served_floor <= retire_floor;

            case (state)
                ST_IDLE: begin
                    if (pending != '0) state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (cur_hit) begin
                        state <= ST_IDLE;
                    end else if (pick_found) begin
                        tgt_floor <= pick_target;
                        dir_up    <= pick_dir;
                        tgt_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (busy_i) begin
                        tgt_valid <= 1'b0;
                        state     <= ST_WAIT;
                    end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        tgt_valid <= 1'b0;
                        state     <= ST_SELECT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!busy_i) state <= retire_v ? ST_IDLE : ST_SELECT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tgt_valid_o    = tgt_valid;
    assign tgt_floor_o    = tgt_floor;
    assign dir_up_o       = dir_up;
    assign pending_o      = pending;
    assign served_o       = served;
    assign served_floor_o = served_floor;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: SCAN selection table plus
// hand-written multi-cycle sequences (handshake, timeout, collisions, limits).
module tb_lift_call_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hall_call_v = 1'b0;
    logic [2:0] hall_call_floor = '0;
    logic       cab_call_v = 1'b0;
    logic [2:0] cab_call_floor = '0;
    logic [2:0] elev_f = '0;
    logic       busy = 1'b0;

    logic       tgt_valid;
    logic [2:0] tgt_floor;
    logic       dir_up;
    logic [7:0] pending;
    logic       served;
    logic [2:0] served_floor;

    logic       tgt_valid6;
    logic [2:0] tgt_floor6;
    logic       dir_up6;
    logic [5:0] pending6;
    logic       served6;
    logic [2:0] served_floor6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lift_call_scheduler #(.NUM_FLOORS(8), .FLOOR_W(3), .ACK_TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .hall_call_v     (hall_call_v),
        .hall_call_floor (hall_call_floor),
        .cab_call_v      (cab_call_v),
        .cab_call_floor  (cab_call_floor),
        .elev_f_i        (elev_f),
        .busy_i          (busy),
        .tgt_valid_o     (tgt_valid),
        .tgt_floor_o     (tgt_floor),
        .dir_up_o        (dir_up),
        .pending_o       (pending),
        .served_o        (served),
        .served_floor_o  (served_floor)
    );

    lift_call_scheduler #(.NUM_FLOORS(6), .FLOOR_W(3), .ACK_TIMEOUT(16)) dut6 (
        .clk             (clk),
        .rst             (rst),
        .hall_call_v     (hall_call_v),
        .hall_call_floor (hall_call_floor),
        .cab_call_v      (cab_call_v),
        .cab_call_floor  (cab_call_floor),
        .elev_f_i        (elev_f),
        .busy_i          (busy),
        .tgt_valid_o     (tgt_valid6),
        .tgt_floor_o     (tgt_floor6),
        .dir_up_o        (dir_up6),
        .pending_o       (pending6),
        .served_o        (served6),
        .served_floor_o  (served_floor6)
    );

    typedef struct {
        logic [7:0] mask;
        logic [2:0] cur;
        logic       exp_retire;
        logic [2:0] exp_floor;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        hall_call_v = 1'b0;
        cab_call_v  = 1'b0;
        busy        = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_tgt(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (tgt_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("tgt_valid_timeout", 32'd0, 32'd1);
    endtask

    // Lift model: accept the target, travel for two cycles, stop at the target.
    task automatic serve(input string name, input logic [2:0] exp_floor, input logic exp_dir);
        bit         ok;
        logic [2:0] dest;
        wait_tgt(ok);
        if (!ok) return;
        check({name, "_floor"}, tgt_floor, exp_floor);
        check({name, "_dir"}, dir_up, exp_dir);
        dest = tgt_floor;
        busy = 1'b1;
        tick();
        tick();
        elev_f = dest;
        busy   = 1'b0;
        tick();
        check({name, "_served"}, served, 1'b1);
        check({name, "_served_floor"}, served_floor, exp_floor);
    endtask

    initial begin
        bit         ok;
        int         cnt;
        int         served_cnt;
        logic [2:0] sfloor;
        bit         saw_valid;
        int         fl[$];

        vecs[0] = '{8'h08, 3'd0, 1'b0, 3'd3, 1'b1};
        vecs[1] = '{8'h52, 3'd2, 1'b0, 3'd4, 1'b1};
        vecs[2] = '{8'h0A, 3'd5, 1'b0, 3'd3, 1'b0};
        vecs[3] = '{8'h41, 3'd7, 1'b0, 3'd6, 1'b0};
        vecs[4] = '{8'h80, 3'd0, 1'b0, 3'd7, 1'b1};
        vecs[5] = '{8'h54, 3'd4, 1'b1, 3'd4, 1'b1};
        vecs[6] = '{8'h27, 3'd3, 1'b0, 3'd5, 1'b1};
        vecs[7] = '{8'h85, 3'd6, 1'b0, 3'd7, 1'b1};

        // Reset with calls asserted throughout.
        rst             = 1'b1;
        hall_call_v     = 1'b1;
        hall_call_floor = 3'd2;
        cab_call_v      = 1'b1;
        cab_call_floor  = 3'd5;
        tick();
        tick();
        rst         = 1'b0;
        hall_call_v = 1'b0;
        cab_call_v  = 1'b0;
        check("rst_pending", pending, 8'h00);
        check("rst_tgt_valid", tgt_valid, 1'b0);
        check("rst_dir_up", dir_up, 1'b1);
        check("rst_served", served, 1'b0);
        check("rst_tgt_floor", tgt_floor, 3'd0);
        tick();
        check("rst_pending_after", pending, 8'h00);

        // Single call: two-cycle issue latency, ack, arrival with collision.
        elev_f          = 3'd0;
        hall_call_v     = 1'b1;
        hall_call_floor = 3'd3;
        tick();
        hall_call_v = 1'b0;
        check("single_pending", pending, 8'h08);
        check("single_valid_n", tgt_valid, 1'b0);
        tick();
        check("single_valid_n1", tgt_valid, 1'b0);
        tick();
        check("single_valid_n2", tgt_valid, 1'b1);
        check("single_floor", tgt_floor, 3'd3);
        busy = 1'b1;
        tick();
        check("single_ack_drop", tgt_valid, 1'b0);
        tick();
        check("single_moving_no_serve", served, 1'b0);
        elev_f         = 3'd3;
        busy           = 1'b0;
        cab_call_v     = 1'b1;
        cab_call_floor = 3'd3;
        tick();
        cab_call_v = 1'b0;
        check("single_served", served, 1'b1);
        check("single_served_floor", served_floor, 3'd3);
        check("collision_pending", pending, 8'h00);
        tick();
        check("single_served_pulse", served, 1'b0);
        check("single_idle_valid", tgt_valid, 1'b0);

        // Call at the current floor is retired without issuing a target.
        elev_f         = 3'd5;
        cab_call_v     = 1'b1;
        cab_call_floor = 3'd5;
        tick();
        cab_call_v = 1'b0;
        check("here_pending", pending, 8'h20);
        served_cnt = 0;
        sfloor     = '0;
        saw_valid  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (served) begin
                served_cnt++;
                sfloor = served_floor;
            end
            if (tgt_valid) saw_valid = 1'b1;
        end
        check("here_served_cnt", served_cnt, 1);
        check("here_served_floor", sfloor, 3'd5);
        check("here_no_valid", saw_valid, 1'b0);
        check("here_pending_after", pending, 8'h00);

        // SCAN order from floor 2 going up with {1,4,6}.
        do_reset();
        elev_f          = 3'd2;
        hall_call_v     = 1'b1;
        hall_call_floor = 3'd1;
        cab_call_v      = 1'b1;
        cab_call_floor  = 3'd4;
        tick();
        hall_call_floor = 3'd6;
        cab_call_v      = 1'b0;
        tick();
        hall_call_v = 1'b0;
        check("scan_pending", pending, 8'h52);
        serve("scan_1st", 3'd4, 1'b1);
        serve("scan_2nd", 3'd6, 1'b1);
        serve("scan_3rd", 3'd1, 1'b0);
        check("scan_pending_end", pending, 8'h00);

        // Ack timeout: valid held 16 cycles, one SELECT cycle, then reissued.
        do_reset();
        elev_f          = 3'd0;
        hall_call_v     = 1'b1;
        hall_call_floor = 3'd2;
        tick();
        hall_call_v = 1'b0;
        wait_tgt(ok);
        cnt = 0;
        while (tgt_valid && cnt < 40) begin
            cnt++;
            tick();
        end
        check("timeout_len", cnt, 16);
        tick();
        check("timeout_reissue", tgt_valid, 1'b1);
        check("timeout_floor", tgt_floor, 3'd2);
        check("timeout_pending", pending, 8'h04);

        // Same floor on hall and cab in one cycle; out-of-range on the 6-floor build.
        do_reset();
        elev_f          = 3'd0;
        hall_call_v     = 1'b1;
        hall_call_floor = 3'd7;
        cab_call_v      = 1'b1;
        cab_call_floor  = 3'd7;
        tick();
        hall_call_v = 1'b0;
        cab_call_v  = 1'b0;
        check("dual7_pending", pending, 8'h80);

        do_reset();
        hall_call_v     = 1'b1;
        hall_call_floor = 3'd6;
        cab_call_v      = 1'b1;
        cab_call_floor  = 3'd7;
        tick();
        cab_call_v = 1'b0;
        check("nf6_ignore", pending6, 6'h00);
        check("nf8_accept", pending, 8'hC0);
        hall_call_floor = 3'd5;
        tick();
        hall_call_v = 1'b0;
        check("nf6_top_floor", pending6, 6'h20);

        // Selection table, each row from a fresh reset (direction up).
        foreach (vecs[r]) begin
            do_reset();
            elev_f = vecs[r].cur;
            fl.delete();
            for (int i = 0; i < 8; i++) if (vecs[r].mask[i]) fl.push_back(i);
            for (int i = 0; i < fl.size(); i += 2) begin
                hall_call_v     = 1'b1;
                hall_call_floor = 3'(fl[i]);
                cab_call_v      = (i + 1 < fl.size());
                cab_call_floor  = (i + 1 < fl.size()) ? 3'(fl[i+1]) : 3'd0;
                tick();
            end
            hall_call_v = 1'b0;
            cab_call_v  = 1'b0;
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (tgt_valid || served) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            check($sformatf("vec%0d_event", r), ok, 1'b1);
            check($sformatf("vec%0d_retire", r), served, vecs[r].exp_retire);
            check($sformatf("vec%0d_floor", r), served ? served_floor : tgt_floor, vecs[r].exp_floor);
            check($sformatf("vec%0d_dir", r), dir_up, vecs[r].exp_dir);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lift_call_scheduler.md
Name: lift_call_scheduler

Overview:
- Upstream stage of the Lift controller. Collects hall calls and in-cabin floor buttons into a pending-floor bitmap.
- Picks the next target with a direction-preserving (SCAN) policy and hands one target floor at a time to Lift.
- Uses Lift's busy/floor outputs to detect arrival and retire the served request.

Parameters:
- NUM_FLOORS, 8, number of served floors (floors 0..NUM_FLOORS-1).
- FLOOR_W, 3, width of floor-number fields; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- ACK_TIMEOUT, 16, cycles to wait for Lift to accept a target before re-selecting.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- hall_call_v  in  1  hall call strobe; one floor per cycle.
- hall_call_floor  in  FLOOR_W  floor on which the hall call button was pressed.
- cab_call_v  in  1  cabin button strobe.
- cab_call_floor  in  FLOOR_W  floor selected inside the cabin.
- elev_f_i  in  FLOOR_W  current cabin floor, from Lift.
- busy_i  in  1  Lift moving/occupied, from Lift.
- tgt_valid_o  out  1  target-floor request to Lift.
- tgt_floor_o  out  FLOOR_W  target floor; stable while tgt_valid_o is high.
- dir_up_o  out  1  current sweep direction (1 = up).
- pending_o  out  NUM_FLOORS  pending-floor bitmap.
- served_o  out  1  one-cycle pulse when a floor request is retired.
- served_floor_o  out  FLOOR_W  floor retired; valid with served_o.

Behaviour:
- Reset (synchronous, rst=1 at an edge) sets:
  - pending 0, dir_up 1, state IDLE, tgt_valid 0, tgt_floor 0, served 0, served_floor 0, timeout counter 0.
  - Reset mid-operation drops all pending calls and any outstanding target.
- Capture:
  - A strobe with floor < NUM_FLOORS sets pending[floor] at the next edge.
  - Floors >= NUM_FLOORS are ignored.
  - Hall and cab strobes in the same cycle both set their bits; the same floor on both sets it once.
  - A repeat call for an already-pending floor is idempotent.
- Set/clear collision: when a retire clears a bit in the same cycle a new call sets it, clear wins (the cabin is at that floor).
- FSM states:
  - IDLE: if pending != 0, go to SELECT next cycle; otherwise stay.
  - SELECT (one cycle), with cur = elev_f_i:
    - If pending[cur] is set: retire cur (clear the bit, served pulse), go to IDLE.
    - Else if dir up: choose the lowest pending floor > cur. If none, flip dir and choose the highest pending floor < cur.
    - Down is symmetric: choose the highest pending floor < cur; if none, flip dir and choose the lowest pending floor > cur.
    - If pending became empty (cleared by a collision), go to IDLE.
    - Otherwise register tgt_floor and go to ISSUE.
  - ISSUE:
    - tgt_valid_o = 1 and the counter increments.
    - busy_i = 1 is the acknowledge: drop tgt_valid and go to WAIT.
    - Counter reaching ACK_TIMEOUT-1 without acknowledge: drop tgt_valid, go to SELECT.
  - WAIT:
    - Hold until busy_i = 0.
    - If elev_f_i == tgt_floor: retire tgt_floor, go to IDLE.
    - Else (Lift stopped elsewhere): go to SELECT; nothing is retired.
- Latency: a call sampled at edge N sets pending at N. SELECT runs at N+1. tgt_valid_o is high from edge N+2 when starting from IDLE.
- New calls arriving during ISSUE/WAIT only update pending; the target is never changed while issued.
- served_o is registered and lasts exactly one cycle per retire.

Decomposition:
- Shared package lift_pkg:
  - State enum (IDLE, SELECT, ISSUE, WAIT).
  - NUM_FLOORS / FLOOR_W defaults.
  - Direction constants DIR_UP / DIR_DOWN.
- Sub-module lift_target_pick: purely combinational priority search over pending, cur and dir. Outputs found, target and new_dir.

Test Plan:
- Reset: hold rst 2 cycles, with calls asserted -> pending_o=0, tgt_valid_o=0, dir_up_o=1 after release.
- Single call: elev_f_i=0, hall call floor 3 -> tgt_valid_o=1 with tgt_floor_o=3 two cycles later. Model busy_i 1 then 0 with elev_f_i=3 -> served_o pulse, served_floor_o=3, pending_o=0.
- SCAN order: elev_f_i=2, dir up, pending {1,4,6} -> targets issued in order 4, 6, 1; dir_up_o becomes 0 before 1 is issued.
- Call at current floor: elev_f_i=5, cab call 5 -> served_o with floor 5, tgt_valid_o never asserts.
- Timeout: busy_i held 0 during ISSUE -> tgt_valid_o drops after 16 cycles, then re-asserts for the same floor.
- Boundaries:
  - Cab call floor 7 and hall call floor 7 in the same cycle -> a single pending bit.
  - A call to floor 3 during its retire cycle -> pending[3]=0 afterward.
  - With NUM_FLOORS=6, a call to floor 6 is ignored.
